// File: rtl/lsu_pkg.sv
// Shared constants for the load/store access controller: width codes,
// FSM state encoding and byte-lane masks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H2 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

endpackage

// File: rtl/ram_w_data_align.sv
// Byte-lane placement and mask generation for a big-endian data RAM.
// Used for both the store data/mask and the load read mask.
module ram_w_data_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] w_data,
  output logic [31:0] lane_data,
  output logic [3:0]  mask,
  output logic        illegal
);

  always_comb begin
    lane_data = '0;
    mask      = '0;
    illegal   = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        illegal = we && (funct3 == F3_BU);
        case (offset)
          2'd0:    mask = MASK_B0;
          2'd1:    mask = MASK_B1;
          2'd2:    mask = MASK_B2;
          default: mask = MASK_B3;
        endcase
        lane_data = {24'b0, w_data[7:0]} << {offset, 3'b000};
      end
      F3_H, F3_HU: begin
        illegal = offset[0] || (we && (funct3 == F3_HU));
        // Big-endian: the high byte of the half lands in the lower-addressed lane.
        if (offset[1]) begin
          mask      = MASK_H2;
          lane_data = {w_data[7:0], w_data[15:8], 16'b0};
        end else begin
          mask      = MASK_H0;
          lane_data = {16'b0, w_data[7:0], w_data[15:8]};
        end
      end
      F3_W: begin
        illegal   = (offset != 2'b00);
        mask      = MASK_W;
        lane_data = {w_data[7:0], w_data[15:8], w_data[23:16], w_data[31:24]};
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      mask      = '0;
      lane_data = '0;
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store access controller: one req/ack RAM transaction per MEM-stage
// access, stalling the pipeline until the RESP cycle.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_funct3_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_w_data_i,
  output logic              lsu_stall_o,
  output logic              lsu_done_o,
  output logic              lsu_misalign_o,
  output logic [31:0]       lsu_r_raw_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_w_data_o,
  output logic [3:0]        ram_w_mask_o,
  input  logic              ram_ack_i,
  input  logic [31:0]       ram_r_data_i,
  output logic [3:0]        ram_r_mask_o,
  output logic              ram_r_sign_ext_o
);

  logic [1:0]  state;
  logic [31:0] lane_data;
  logic [3:0]  lane_mask;
  logic        illegal;

  ram_w_data_align u_align (
    .we        (lsu_we_i),
    .funct3    (lsu_funct3_i),
    .offset    (lsu_addr_i[1:0]),
    .w_data    (lsu_w_data_i),
    .lane_data (lane_data),
    .mask      (lane_mask),
    .illegal   (illegal)
  );

  assign lsu_stall_o = ((state == ST_IDLE) && lsu_valid_i) || (state == ST_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      lsu_done_o       <= 1'b0;
      lsu_misalign_o   <= 1'b0;
      lsu_r_raw_o      <= '0;
      ram_req_o        <= 1'b0;
      ram_we_o         <= 1'b0;
      ram_addr_o       <= '0;
      ram_w_data_o     <= '0;
      ram_w_mask_o     <= '0;
      ram_r_mask_o     <= '0;
      ram_r_sign_ext_o <= 1'b0;
    end else begin
      lsu_done_o     <= 1'b0;
      lsu_misalign_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (lsu_valid_i) begin
            if (illegal) begin
              state          <= ST_RESP;
              lsu_done_o     <= 1'b1;
              lsu_misalign_o <= 1'b1;
            end else begin
              state            <= ST_BUSY;
              ram_req_o        <= 1'b1;
              ram_we_o         <= lsu_we_i;
              ram_addr_o       <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
              ram_w_data_o     <= lsu_we_i ? lane_data : 32'b0;
              ram_w_mask_o     <= lsu_we_i ? lane_mask : 4'b0;
              ram_r_mask_o     <= lsu_we_i ? 4'b0 : lane_mask;
              ram_r_sign_ext_o <= !lsu_we_i &&
                                  ((lsu_funct3_i == F3_B) || (lsu_funct3_i == F3_H));
            end
          end
        end
        ST_BUSY: begin
          if (ram_ack_i) begin
            state        <= ST_RESP;
            lsu_done_o   <= 1'b1;
            ram_req_o    <= 1'b0;
            ram_we_o     <= 1'b0;
            ram_w_data_o <= '0;
            ram_w_mask_o <= '0;
            if (!ram_we_o) lsu_r_raw_o <= ram_r_data_i;
          end
        end
        ST_RESP: begin
          // Read mask/sign flag are consumed by the extender during RESP.
          state            <= ST_IDLE;
          ram_r_mask_o     <= '0;
          ram_r_sign_ext_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed table, hand sequences for
// back-to-back and reset corners, then random accesses against a byte model.
module tb_lsu_mem_ctrl;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;
    logic        mis;
    logic [31:0] e_addr;
    logic [3:0]  e_wmask;
    logic [31:0] e_wdata;
    logic [3:0]  e_rmask;
    logic        e_sext;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_w_data;
  logic        lsu_stall, lsu_done, lsu_misalign;
  logic [31:0] lsu_r_raw;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr, ram_w_data;
  logic [3:0]  ram_w_mask, ram_r_mask;
  logic        ram_ack, ram_r_sign_ext;
  logic [31:0] ram_r_data;

  int n_vec = 0;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] raw_model = '0;

  lsu_mem_ctrl #(.ADDR_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_valid_i      (lsu_valid),
    .lsu_we_i         (lsu_we),
    .lsu_funct3_i     (lsu_funct3),
    .lsu_addr_i       (lsu_addr),
    .lsu_w_data_i     (lsu_w_data),
    .lsu_stall_o      (lsu_stall),
    .lsu_done_o       (lsu_done),
    .lsu_misalign_o   (lsu_misalign),
    .lsu_r_raw_o      (lsu_r_raw),
    .ram_req_o        (ram_req),
    .ram_we_o         (ram_we),
    .ram_addr_o       (ram_addr),
    .ram_w_data_o     (ram_w_data),
    .ram_w_mask_o     (ram_w_mask),
    .ram_ack_i        (ram_ack),
    .ram_r_data_i     (ram_r_data),
    .ram_r_mask_o     (ram_r_mask),
    .ram_r_sign_ext_o (ram_r_sign_ext)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int k,
                              input logic mis, input logic [31:0] e_addr, input logic [3:0] e_wmask,
                              input logic [31:0] e_wdata, input logic [3:0] e_rmask,
                              input logic e_sext);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.k = k;
    v.mis = mis; v.e_addr = e_addr; v.e_wmask = e_wmask; v.e_wdata = e_wdata;
    v.e_rmask = e_rmask; v.e_sext = e_sext;
    return v;
  endfunction

  // Reference: access of n bytes at offset o; byte i of the access (lowest
  // address first) is the i-th most significant of the value's low n bytes.
  function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int k);
    vec_t v;
    int   n;
    int   o;
    logic ok;
    logic signed_ld;
    v = mk(we, f3, addr, wdata, rdata, k, 1'b0, {addr[31:2], 2'b00}, 4'b0, 32'b0, 4'b0, 1'b0);
    ok = 1'b1;
    signed_ld = 1'b0;
    case (f3)
      3'b000: begin n = 1; signed_ld = 1'b1; end
      3'b001: begin n = 2; signed_ld = 1'b1; end
      3'b010: n = 4;
      3'b100: begin n = 1; ok = !we; end
      3'b101: begin n = 2; ok = !we; end
      default: begin n = 1; ok = 1'b0; end
    endcase
    o = int'(addr[1:0]);
    if ((o % n) != 0) ok = 1'b0;
    v.mis = !ok;
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        if (we) begin
          v.e_wmask[o+i] = 1'b1;
          v.e_wdata[8*(o+i) +: 8] = wdata[8*(n-1-i) +: 8];
        end else begin
          v.e_rmask[o+i] = 1'b1;
        end
      end
      v.e_sext = !we && signed_ld;
    end
    return v;
  endfunction

  // Entered and left in IDLE, one ns after a rising edge.
  task automatic run_access(input vec_t v);
    logic [31:0] exp_raw;
    n_vec++;
    exp_raw = (v.mis || v.we) ? raw_model : v.rdata;
    lsu_valid = 1'b1; lsu_we = v.we; lsu_funct3 = v.f3;
    lsu_addr = v.addr; lsu_w_data = v.wdata;
    #1;
    check("stall_accept", 32'(lsu_stall), 32'd1);
    check("req_before_accept", 32'(ram_req), 32'd0);
    tick();
    lsu_we = $urandom; lsu_funct3 = $urandom; lsu_addr = $urandom; lsu_w_data = $urandom;
    if (v.mis) begin
      check("ill_done", 32'(lsu_done), 32'd1);
      check("ill_misalign", 32'(lsu_misalign), 32'd1);
      check("ill_req", 32'(ram_req), 32'd0);
      check("ill_stall", 32'(lsu_stall), 32'd0);
      check("ill_rmask", 32'(ram_r_mask), 32'd0);
    end else begin
      for (int c = 1; c <= v.k; c++) begin
        if (c == v.k) begin
          ram_ack = 1'b1;
          ram_r_data = v.rdata;
        end
        #1;
        check("busy_req", 32'(ram_req), 32'd1);
        check("busy_stall", 32'(lsu_stall), 32'd1);
        check("busy_done", 32'(lsu_done), 32'd0);
        check("busy_we", 32'(ram_we), 32'(v.we));
        check("busy_addr", ram_addr, v.e_addr);
        check("busy_wmask", 32'(ram_w_mask), 32'(v.e_wmask));
        check("busy_wdata", ram_w_data, v.e_wdata);
        check("busy_rmask", 32'(ram_r_mask), 32'(v.e_rmask));
        check("busy_sext", 32'(ram_r_sign_ext), 32'(v.e_sext));
        tick();
      end
      ram_ack = 1'b0;
      ram_r_data = $urandom;
      #1;
      check("resp_done", 32'(lsu_done), 32'd1);
      check("resp_misalign", 32'(lsu_misalign), 32'd0);
      check("resp_req", 32'(ram_req), 32'd0);
      check("resp_stall", 32'(lsu_stall), 32'd0);
      check("resp_raw", lsu_r_raw, exp_raw);
      check("resp_rmask", 32'(ram_r_mask), 32'(v.e_rmask));
      check("resp_sext", 32'(ram_r_sign_ext), 32'(v.e_sext));
    end
    raw_model = exp_raw;
    // A stray ack in RESP must be ignored.
    lsu_valid = 1'b0;
    ram_ack = 1'($urandom);
    ram_r_data = $urandom;
    tick();
    ram_ack = 1'b0;
    check("idle_done", 32'(lsu_done), 32'd0);
    check("idle_misalign", 32'(lsu_misalign), 32'd0);
    check("idle_req", 32'(ram_req), 32'd0);
    check("idle_rmask", 32'(ram_r_mask), 32'd0);
    check("idle_sext", 32'(ram_r_sign_ext), 32'd0);
    check("idle_raw", lsu_r_raw, exp_raw);
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    tbl[0]  = mk(1, 3'b010, 32'h100, 32'h11223344, 32'h0, 2, 0, 32'h100, 4'b1111, 32'h44332211, 4'b0000, 0);
    tbl[1]  = mk(1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1, 0, 32'h100, 4'b1100, 32'hCDAB0000, 4'b0000, 0);
    tbl[2]  = mk(0, 3'b000, 32'h103, 32'h0, 32'h80000000, 1, 0, 32'h100, 4'b0000, 32'h0, 4'b1000, 1);
    tbl[3]  = mk(0, 3'b101, 32'h101, 32'h0, 32'h0, 1, 1, 32'h0, 4'b0, 32'h0, 4'b0, 0);
    tbl[4]  = mk(1, 3'b000, 32'h001, 32'h1234565A, 32'h0, 3, 0, 32'h0, 4'b0010, 32'h00005A00, 4'b0000, 0);
    tbl[5]  = mk(0, 3'b001, 32'h202, 32'h0, 32'h1234ABCD, 2, 0, 32'h200, 4'b0000, 32'h0, 4'b1100, 1);
    tbl[6]  = mk(0, 3'b100, 32'h102, 32'h0, 32'h55667788, 4, 0, 32'h100, 4'b0000, 32'h0, 4'b0100, 0);
    tbl[7]  = mk(0, 3'b010, 32'h206, 32'h0, 32'h0, 1, 1, 32'h0, 4'b0, 32'h0, 4'b0, 0);
    tbl[8]  = mk(0, 3'b011, 32'h300, 32'h0, 32'h0, 1, 1, 32'h0, 4'b0, 32'h0, 4'b0, 0);
    tbl[9]  = mk(1, 3'b100, 32'h300, 32'h0, 32'h0, 1, 1, 32'h0, 4'b0, 32'h0, 4'b0, 0);
    tbl[10] = mk(1, 3'b001, 32'h400, 32'hFFFF1357, 32'h0, 1, 0, 32'h400, 4'b0011, 32'h00005713, 4'b0000, 0);
    tbl[11] = mk(1, 3'b000, 32'h403, 32'h00000099, 32'h0, 2, 0, 32'h400, 4'b1000, 32'h99000000, 4'b0000, 0);

    rst = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = '0; lsu_addr = '0;
    lsu_w_data = '0; ram_ack = 1'b0; ram_r_data = '0;
    tick(); tick();
    check("rst_req", 32'(ram_req), 32'd0);
    check("rst_done", 32'(lsu_done), 32'd0);
    check("rst_stall", 32'(lsu_stall), 32'd0);
    check("rst_raw", lsu_r_raw, 32'd0);
    check("rst_wmask", 32'(ram_w_mask), 32'd0);
    check("rst_addr", ram_addr, 32'd0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) run_access(tbl[i]);

    // Back-to-back LW: valid held through RESP must not issue early.
    n_vec += 2;
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h200;
    tick();
    ram_ack = 1'b1; ram_r_data = 32'hA1B2C3D4;
    #1;
    check("b2b_req1", 32'(ram_req), 32'd1);
    check("b2b_addr1", ram_addr, 32'h200);
    tick();
    ram_ack = 1'b0; lsu_addr = 32'h204;
    #1;
    check("b2b_done1", 32'(lsu_done), 32'd1);
    check("b2b_raw1", lsu_r_raw, 32'hA1B2C3D4);
    check("b2b_rmask1", 32'(ram_r_mask), 32'hF);
    check("b2b_stall_resp", 32'(lsu_stall), 32'd0);
    tick();
    check("b2b_no_req_resp", 32'(ram_req), 32'd0);
    check("b2b_done_gap", 32'(lsu_done), 32'd0);
    check("b2b_stall_acc2", 32'(lsu_stall), 32'd1);
    tick();
    ram_ack = 1'b1; ram_r_data = 32'h0F1E2D3C; lsu_valid = 1'b0;
    #1;
    check("b2b_req2", 32'(ram_req), 32'd1);
    check("b2b_addr2", ram_addr, 32'h204);
    check("b2b_sext2", 32'(ram_r_sign_ext), 32'd0);
    tick();
    ram_ack = 1'b0;
    check("b2b_done2", 32'(lsu_done), 32'd1);
    check("b2b_raw2", lsu_r_raw, 32'h0F1E2D3C);
    tick();
    check("b2b_idle_rmask", 32'(ram_r_mask), 32'd0);
    raw_model = 32'h0F1E2D3C;

    // Reset mid-BUSY abandons the access.
    n_vec++;
    lsu_valid = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'b010; lsu_addr = 32'h500; lsu_w_data = 32'hDEADBEEF;
    tick();
    lsu_valid = 1'b0;
    check("mid_req_before_rst", 32'(ram_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(ram_req), 32'd0);
    check("mid_rst_we", 32'(ram_we), 32'd0);
    check("mid_rst_wmask", 32'(ram_w_mask), 32'd0);
    check("mid_rst_wdata", ram_w_data, 32'd0);
    check("mid_rst_addr", ram_addr, 32'd0);
    check("mid_rst_raw", lsu_r_raw, 32'd0);
    check("mid_rst_stall", 32'(lsu_stall), 32'd0);
    ram_ack = 1'b1;
    tick();
    check("mid_rst_done", 32'(lsu_done), 32'd0);
    ram_ack = 1'b0;
    rst = 1'b0;
    raw_model = '0;
    tick();
    run_access(mk(0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 1, 0, 32'h300, 4'b0, 32'h0, 4'b1111, 0));

    for (int i = 0; i < 80; i++) begin
      rv = model(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(1, 4)));
      run_access(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
